// File: rtl/cache_pkg.sv
// Shared geometry and line layout for the 4-way set-associative cache.
// Every stage that slices a stored line takes its field positions from here.
package cache_pkg;

  localparam int WAYS           = 4;
  localparam int WAY_BITS       = $clog2(WAYS);
  localparam int TAG_BITS       = 18;
  localparam int LINE_SIZE_BITS = 32;
  localparam int LINE_WIDTH     = 3 + TAG_BITS + LINE_SIZE_BITS;

  // Stored line layout, MSB first: valid, dirty, LRU, tag, data
  localparam int VALID_POS = LINE_WIDTH - 1;
  localparam int DIRTY_POS = LINE_WIDTH - 2;
  localparam int LRU_POS   = LINE_WIDTH - 3;
  localparam int TAG_MSB   = LINE_WIDTH - 4;
  localparam int TAG_LSB   = LINE_SIZE_BITS;

  typedef struct packed {
    logic                      valid;
    logic                      dirty;
    logic                      lru;
    logic [TAG_BITS-1:0]       tag;
    logic [LINE_SIZE_BITS-1:0] data;
  } line_t;

  // True when more than one bit of the vector is set
  function automatic logic more_than_one(input logic [WAYS-1:0] vec);
    return |(vec & (vec - {{(WAYS-1){1'b0}}, 1'b1}));
  endfunction

endpackage

// File: rtl/way_tag_match.sv
// Per-way hit detector: tag equality gated by the way's valid bit.
// Purely combinational; one instance per way.
module way_tag_match
  import cache_pkg::*;
(
  input  logic                valid_i,
  input  logic [TAG_BITS-1:0] line_tag_i,
  input  logic [TAG_BITS-1:0] lookup_tag_i,
  output logic                match_o
);

  // An invalid line never hits, even if its stale tag happens to match
  assign match_o = valid_i && (line_tag_i == lookup_tag_i);

endmodule

// File: rtl/sa_way_select.sv
// Hit detection and line select for one indexed set: per-way match, highest-index
// priority, one-hot AND-OR mux, and a single registered output stage.
module sa_way_select
  import cache_pkg::*;
(
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      i_lookup,
  input  logic [TAG_BITS-1:0]       i_tag,
  input  logic [LINE_WIDTH-1:0]     i_line0,
  input  logic [LINE_WIDTH-1:0]     i_line1,
  input  logic [LINE_WIDTH-1:0]     i_line2,
  input  logic [LINE_WIDTH-1:0]     i_line3,
  output logic                      o_valid,
  output logic                      o_hit,
  output logic [WAYS-1:0]           o_hit_vec,
  output logic [WAY_BITS-1:0]       o_hit_way,
  output logic                      o_multi_hit,
  output logic [LINE_WIDTH-1:0]     o_line,
  output logic [LINE_SIZE_BITS-1:0] o_data
);

  logic [LINE_WIDTH-1:0] lines [WAYS];
  logic [WAYS-1:0]       match;

  assign lines[0] = i_line0;
  assign lines[1] = i_line1;
  assign lines[2] = i_line2;
  assign lines[3] = i_line3;

  for (genvar g = 0; g < WAYS; g++) begin : g_way
    way_tag_match u_match (
      .valid_i      (lines[g][VALID_POS]),
      .line_tag_i   (lines[g][TAG_MSB:TAG_LSB]),
      .lookup_tag_i (i_tag),
      .match_o      (match[g])
    );
  end

  logic [WAYS-1:0]       sel_vec;
  logic [WAY_BITS-1:0]   hit_way_d;
  logic [LINE_WIDTH-1:0] line_d;

  // NOTE: every always_comb output gets a default first so no path leaves it
  // unassigned; otherwise synthesis infers a latch to hold the old value.
  always_comb begin
    sel_vec   = '0;
    hit_way_d = '0;
    line_d    = '0;
    // Ascending scan: a later (higher-index) match overwrites earlier ones
    for (int w = 0; w < WAYS; w++) begin
      if (match[w]) begin
        sel_vec    = '0;
        sel_vec[w] = 1'b1;
        hit_way_d  = WAY_BITS'(w);
      end
    end
    // One-hot AND-OR: unselected ways contribute zeros, never X from an index
    for (int w = 0; w < WAYS; w++) begin
      line_d = line_d | (lines[w] & {LINE_WIDTH{sel_vec[w]}});
    end
  end

  logic                valid_q;
  logic                hit_q;
  logic [WAYS-1:0]     hit_vec_q;
  logic [WAY_BITS-1:0] hit_way_q;
  logic                multi_hit_q;
  line_t               line_q;

  // NOTE: state updates use non-blocking assignment so every register samples
  // the pre-edge values; blocking here would create order-dependent races.
  always_ff @(posedge clk) begin
    if (rst) begin
      valid_q     <= 1'b0;
      hit_q       <= 1'b0;
      hit_vec_q   <= '0;
      hit_way_q   <= '0;
      multi_hit_q <= 1'b0;
      line_q      <= '0;
    end else begin
      valid_q <= i_lookup;
      if (i_lookup) begin
        hit_q       <= |match;
        hit_vec_q   <= match;
        hit_way_q   <= hit_way_d;
        multi_hit_q <= more_than_one(match);
        line_q      <= line_d;
      end
    end
  end

  assign o_valid     = valid_q;
  assign o_hit       = hit_q;
  assign o_hit_vec   = hit_vec_q;
  assign o_hit_way   = hit_way_q;
  assign o_multi_hit = multi_hit_q;
  assign o_line      = line_q;
  assign o_data      = line_q.data;

endmodule

// File: tb/tb_sa_way_select.sv
// Self-checking bench for sa_way_select: directed scenarios plus random lookups
// compared against a behavioural model of hit/priority/hold semantics.
module tb_sa_way_select;
  import cache_pkg::*;

  logic                      clk = 1'b0;
  logic                      rst;
  logic                      i_lookup;
  logic [TAG_BITS-1:0]       i_tag;
  logic [LINE_WIDTH-1:0]     tb_line [4];
  logic                      o_valid, o_hit, o_multi_hit;
  logic [WAYS-1:0]           o_hit_vec;
  logic [WAY_BITS-1:0]       o_hit_way;
  logic [LINE_WIDTH-1:0]     o_line;
  logic [LINE_SIZE_BITS-1:0] o_data;

  always #5 clk = ~clk;

  sa_way_select dut (
    .clk         (clk),
    .rst         (rst),
    .i_lookup    (i_lookup),
    .i_tag       (i_tag),
    .i_line0     (tb_line[0]),
    .i_line1     (tb_line[1]),
    .i_line2     (tb_line[2]),
    .i_line3     (tb_line[3]),
    .o_valid     (o_valid),
    .o_hit       (o_hit),
    .o_hit_vec   (o_hit_vec),
    .o_hit_way   (o_hit_way),
    .o_multi_hit (o_multi_hit),
    .o_line      (o_line),
    .o_data      (o_data)
  );

  int n_checks = 0;
  int n_fail   = 0;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Model state: what the registered outputs should show after the last edge
  logic        m_valid, m_hit, m_multi;
  logic [3:0]  m_vec;
  logic [1:0]  m_way;
  logic [63:0] m_line;

  function automatic logic [LINE_WIDTH-1:0] mk(input bit v, input bit d, input bit l,
                                               input logic [17:0] t, input logic [31:0] data);
    return {v, d, l, t, data};
  endfunction

  // Evaluate the lookup from the spec's rules using plain shifts and a hit list
  task automatic model_edge();
    int hits[$];
    longint unsigned ln;
    if (rst) begin
      m_valid = 0; m_hit = 0; m_multi = 0; m_vec = 0; m_way = 0; m_line = 0;
    end else begin
      m_valid = i_lookup;
      if (i_lookup) begin
        for (int w = 0; w < 4; w++) begin
          ln = 64'(tb_line[w]);
          if (((ln >> 52) & 1) == 1 && ((ln >> 32) & 64'h3FFFF) == 64'(i_tag))
            hits.push_back(w);
        end
        m_vec = 0;
        foreach (hits[k]) m_vec = m_vec + 4'(1 << hits[k]);
        m_hit   = hits.size() > 0;
        m_multi = hits.size() > 1;
        m_way   = m_hit ? 2'(hits[hits.size()-1]) : 2'd0;
        m_line  = m_hit ? 64'(tb_line[m_way]) : 64'd0;
      end
    end
  endtask

  task automatic step(input string name);
    @(posedge clk);
    model_edge();
    #1;
    check({name, ".valid"}, 64'(o_valid),     64'(m_valid));
    check({name, ".hit"},   64'(o_hit),       64'(m_hit));
    check({name, ".vec"},   64'(o_hit_vec),   64'(m_vec));
    check({name, ".way"},   64'(o_hit_way),   64'(m_way));
    check({name, ".multi"}, 64'(o_multi_hit), 64'(m_multi));
    check({name, ".line"},  64'(o_line),      m_line);
    check({name, ".data"},  64'(o_data),      m_line & 64'hFFFF_FFFF);
  endtask

  function automatic logic [17:0] pick_tag();
    case ($urandom_range(0, 4))
      0:       return 18'h00000;
      1:       return 18'h3FFFF;
      2:       return 18'h00005;
      3:       return 18'h00006;
      default: return 18'($urandom);
    endcase
  endfunction

  initial begin
    rst = 1'b1; i_lookup = 1'b1; i_tag = 18'h00005;
    tb_line[0] = mk(1, 0, 0, 18'h00005, 32'hAAAA5555);
    for (int w = 1; w < 4; w++) tb_line[w] = mk(1, 0, 0, 18'h00100 + 18'(w), 32'(w));
    step("reset0");
    check("reset0_valid_zero", 64'(o_valid), 64'd0);
    step("reset1");
    check("reset1_line_zero", 64'(o_line), 64'd0);
    rst = 1'b0;

    // Single hit on way 2
    tb_line[0] = mk(1, 0, 0, 18'h00001, 32'h01010101);
    tb_line[1] = mk(1, 0, 0, 18'h00002, 32'h02020202);
    tb_line[2] = mk(1, 0, 0, 18'h00005, 32'hDEADBEEF);
    tb_line[3] = mk(1, 0, 0, 18'h00007, 32'h07070707);
    i_tag = 18'h00005;
    step("single");
    check("single_vec", 64'(o_hit_vec), 64'b0100);
    check("single_way", 64'(o_hit_way), 64'd2);
    check("single_data", 64'(o_data), 64'hDEADBEEF);

    // Matching tag on an invalid line is a miss
    tb_line[1] = mk(0, 0, 0, 18'h00003, 32'h33334444);
    i_tag = 18'h00003;
    step("inv_miss");
    check("inv_miss_hit", 64'(o_hit), 64'd0);
    check("inv_miss_valid", 64'(o_valid), 64'd1);

    // Multi-hit: ways 0 and 3, highest index wins
    tb_line[0] = mk(1, 0, 0, 18'h3FFFF, 32'h11111111);
    tb_line[3] = mk(1, 0, 0, 18'h3FFFF, 32'h33333333);
    i_tag = 18'h3FFFF;
    step("multi");
    check("multi_way", 64'(o_hit_way), 64'd3);
    check("multi_flag", 64'(o_multi_hit), 64'd1);
    check("multi_data", 64'(o_data), 64'h33333333);

    // Back-to-back lookups, then hold
    tb_line[0] = mk(1, 0, 0, 18'h0000A, 32'hA0A0A0A0);
    tb_line[1] = mk(1, 0, 0, 18'h0000B, 32'hB1B1B1B1);
    tb_line[3] = mk(1, 0, 0, 18'h0000C, 32'hC3C3C3C3);
    i_tag = 18'h0000A;
    step("b2b0");
    check("b2b0_data", 64'(o_data), 64'hA0A0A0A0);
    i_tag = 18'h0000B;
    step("b2b1");
    check("b2b1_data", 64'(o_data), 64'hB1B1B1B1);
    i_lookup = 1'b0;
    i_tag = 18'h0000A;
    step("hold");
    check("hold_valid", 64'(o_valid), 64'd0);
    check("hold_data", 64'(o_data), 64'hB1B1B1B1);

    // Dirty and LRU pass straight through
    i_lookup = 1'b1;
    tb_line[1] = mk(1, 1, 1, 18'h00022, 32'h5A5A5A5A);
    i_tag = 18'h00022;
    step("pass");
    check("pass_dirty", 64'(o_line[51]), 64'd1);
    check("pass_lru", 64'(o_line[50]), 64'd1);
    check("pass_line", 64'(o_line), 64'(mk(1, 1, 1, 18'h00022, 32'h5A5A5A5A)));

    // Randomized lookups with occasional resets and idle cycles
    for (int n = 0; n < 400; n++) begin
      rst      = ($urandom_range(0, 49) == 0);
      i_lookup = ($urandom_range(0, 3) != 0);
      i_tag    = pick_tag();
      for (int w = 0; w < 4; w++)
        tb_line[w] = mk(bit'($urandom_range(0, 3) != 0), bit'($urandom), bit'($urandom),
                        pick_tag(), 32'($urandom));
      step("rand");
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
